// File: rtl/ifu_fetch_pkg.sv
// Shared core definitions: fetch FSM encoding, reset PC and canonical nop.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Imported by fetch and decode.
package ifu_fetch_pkg;

  // Fetch unit states.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // Boot address and the instruction shown to decode before the first fetch.
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/ifu_fetch_pc_reg.sv
// Program counter register with synchronous reset, load and +4 increment.
// Latency: 1 cycle from load/inc to updated pc.
// Backpressure: none; load has priority over inc.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset (pc <= RESET_VAL)
//   load      - replace pc with load_val
//   load_val  - new pc value
//   inc       - advance pc by 4 (wraps modulo 2^XLEN)
//   pc        - current program counter
module pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, one held instruction.
// Latency: request handshake -> capture 1 cycle min; <=1 instruction per 3 cycles.
// Backpressure: inst held stable until inst_ready; no new request while held.
//
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   imem_req_valid/ready/addr        - fetch request to instruction memory
//   imem_resp_valid/data             - single-cycle response (ignored outside WAIT)
//   inst_valid/ready, inst, inst_pc  - instruction handed to decode
//   redirect_valid, redirect_pc      - branch/jump redirect pulse and target
//   halt                             - stop fetching (ebreak); halted reports HALT
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;          // discard the outstanding response
  logic            halt_pend_q, halt_pend_d; // halt seen while a response is due
  logic            capture;
  logic            pc_load;
  logic            pc_inc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;

  pc_reg #(
    .XLEN      (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (redirect_pc & ~XLEN'(3)),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign imem_req_addr = pc & ~XLEN'(3);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      drop_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      inst_q      <= XLEN'(NOP_INST);
      inst_pc_q   <= RESET_PC;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      halt_pend_q <= halt_pend_d;
      if (capture) begin
        inst_q    <= imem_resp_data;
        inst_pc_q <= pc;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    halt_pend_d    = halt_pend_q;
    capture        = 1'b0;
    pc_load        = 1'b0;
    pc_inc         = 1'b0;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    halted         = 1'b0;

    case (state_q)
      ST_REQ: begin
        // Halt and redirect both suppress the request issued this cycle.
        if (halt) begin
          state_d = ST_HALT;
        end else if (redirect_valid) begin
          pc_load = 1'b1;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // The request is already accepted, so the response must be waited
        // for and absorbed before leaving this state for any reason.
        if (imem_resp_valid) begin
          drop_d      = 1'b0;
          halt_pend_d = 1'b0;
          if (halt || halt_pend_q) begin
            state_d = ST_HALT;
          end else if (drop_q || redirect_valid) begin
            pc_load = redirect_valid;
            state_d = ST_REQ;
          end else begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end else if (redirect_valid && !halt_pend_q) begin
          drop_d  = 1'b1;
          pc_load = 1'b1;
        end
      end

      ST_HOLD: begin
        inst_valid = 1'b1;
        if (halt) begin
          state_d = ST_HALT;
        end else if (redirect_valid) begin
          // Redirect wins over a simultaneous consume.
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else if (inst_ready) begin
          pc_inc  = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase

    if (rst) begin
      imem_req_valid = 1'b0;
      inst_valid     = 1'b0;
      halted         = 1'b0;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .halted          (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From REQ: handshake, then deliver a response one cycle later; ends in HOLD.
  task automatic fetch(input logic [31:0] data);
    imem_req_ready  = 1'b1;
    @(negedge clk);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;

    // Reset state
    @(posedge clk); @(negedge clk); #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_inst_nop", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h8000_0000);

    // Basic fetch
    rst = 1'b0; imem_req_ready = 1'b1; #1;
    chk("req0_valid", 32'(imem_req_valid), 32'd1);
    chk("req0_addr", imem_req_addr, 32'h8000_0000);
    @(negedge clk);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; #1;
    chk("wait_no_req", 32'(imem_req_valid), 32'd0);
    chk("wait_no_inst", 32'(inst_valid), 32'd0);
    @(negedge clk);
    imem_resp_valid = 1'b0; #1;
    chk("hold_valid", 32'(inst_valid), 32'd1);
    chk("hold_inst", inst, 32'h0010_0093);
    chk("hold_pc", inst_pc, 32'h8000_0000);

    // Decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, 32'h0010_0093);
      chk("stall_pc", inst_pc, 32'h8000_0000);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0; #1;
    chk("consume_inst_valid", 32'(inst_valid), 32'd0);
    chk("req1_valid", 32'(imem_req_valid), 32'd1);
    chk("req1_addr", imem_req_addr, 32'h8000_0004);

    // Redirect during WAIT drops the response
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0103; #1;
    chk("wredir_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_resp_valid = 1'b0; #1;
    chk("wredir_no_inst", 32'(inst_valid), 32'd0);
    chk("wredir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wredir_addr", imem_req_addr, 32'h8000_0100);
    chk("wredir_inst_kept", inst, 32'h0010_0093);

    // Redirect in REQ suppresses that cycle's request
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; imem_req_ready = 1'b1; #1;
    chk("rredir_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111; #1;
    chk("rredir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rredir_addr", imem_req_addr, 32'h8000_0200);
    @(negedge clk);
    imem_resp_valid = 1'b0; #1;
    chk("stray_resp_inst", inst, 32'h0010_0093);
    chk("stray_resp_valid", 32'(inst_valid), 32'd0);

    // Redirect together with inst_ready in HOLD
    fetch(32'h0000_0513);
    chk("f2_valid", 32'(inst_valid), 32'd1);
    chk("f2_inst", inst, 32'h0000_0513);
    chk("f2_pc", inst_pc, 32'h8000_0200);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    inst_ready = 1'b0; redirect_valid = 1'b0; #1;
    chk("hredir_inst_valid", 32'(inst_valid), 32'd0);
    chk("hredir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("hredir_addr", imem_req_addr, 32'hFFFF_FFFC);

    // PC wraps from 0xFFFFFFFC to 0
    fetch(32'h0000_0293);
    chk("f3_inst", inst, 32'h0000_0293);
    chk("f3_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0; #1;
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);

    // ebreak then halt pulse
    fetch(32'h0010_0073);
    chk("ebreak_inst", inst, 32'h0010_0073);
    chk("ebreak_pc", inst_pc, 32'h0000_0000);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0; #1;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_inst_valid", 32'(inst_valid), 32'd0);
    chk("halt_no_req", 32'(imem_req_valid), 32'd0);
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("halt_stays", 32'(halted), 32'd1);
      chk("halt_stays_no_req", 32'(imem_req_valid), 32'd0);
    end
    imem_req_ready = 1'b0; redirect_valid = 1'b0;

    // Halt during WAIT: response discarded, then HALT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b1; #1;
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst2_addr", imem_req_addr, 32'h8000_0000);
    @(negedge clk);
    imem_req_ready = 1'b0; halt = 1'b1;
    @(negedge clk);
    halt = 1'b0; #1;
    chk("whalt_pending", 32'(halted), 32'd0);
    chk("whalt_no_req", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
    @(negedge clk);
    imem_resp_valid = 1'b0; #1;
    chk("whalt_halted", 32'(halted), 32'd1);
    chk("whalt_inst_nop", inst, 32'h0000_0013);
    chk("whalt_inst_valid", 32'(inst_valid), 32'd0);

    // Reset mid-transaction; late response ignored
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; imem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_F00D; #1;
    chk("late_req_valid", 32'(imem_req_valid), 32'd1);
    chk("late_addr", imem_req_addr, 32'h8000_0000);
    @(negedge clk);
    imem_resp_valid = 1'b0; #1;
    chk("late_inst_nop", inst, 32'h0000_0013);
    chk("late_inst_valid", 32'(inst_valid), 32'd0);

    // Halt and redirect together: halt wins
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0400; #1;
    chk("hr_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    halt = 1'b0; redirect_valid = 1'b0; #1;
    chk("hr_halted", 32'(halted), 32'd1);
    chk("hr_no_req_after", 32'(imem_req_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
